// File: rtl/apb_bus_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : apb_bus_arbiter_if
// Description : Requester-side and peripheral-side signal bundle for
//               apb_bus_arbiter. The master modport is the arbiter's view;
//               the slave modport is the view of the surrounding logic
//               (requesters and peripheral register blocks).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface apb_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SLAVES = 4
);
  // Requester 0 (host bridge)
  logic                             m0Enable;
  logic                             m0Write;
  logic [ADDR_WIDTH-1:0]            m0Addr;
  logic [DATA_WIDTH-1:0]            m0WData;
  logic                             m0Ready;
  logic [DATA_WIDTH-1:0]            m0RData;
  // Requester 1 (internal DMA/sequencer)
  logic                             m1Enable;
  logic                             m1Write;
  logic [ADDR_WIDTH-1:0]            m1Addr;
  logic [DATA_WIDTH-1:0]            m1WData;
  logic                             m1Ready;
  logic [DATA_WIDTH-1:0]            m1RData;
  // Shared APB bus
  logic [NUM_SLAVES-1:0]            pSel;
  logic                             pEnable;
  logic                             pWrite;
  logic [ADDR_WIDTH-1:0]            pAddr;
  logic [DATA_WIDTH-1:0]            pWData;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] pRData;
  logic [NUM_SLAVES-1:0]            pReady;
  logic                             timeoutErr;

  modport master (
    input  m0Enable, m0Write, m0Addr, m0WData,
    output m0Ready, m0RData,
    input  m1Enable, m1Write, m1Addr, m1WData,
    output m1Ready, m1RData,
    output pSel, pEnable, pWrite, pAddr, pWData,
    input  pRData, pReady,
    output timeoutErr
  );

  modport slave (
    output m0Enable, m0Write, m0Addr, m0WData,
    input  m0Ready, m0RData,
    output m1Enable, m1Write, m1Addr, m1WData,
    input  m1Ready, m1RData,
    input  pSel, pEnable, pWrite, pAddr, pWData,
    output pRData, pReady,
    input  timeoutErr
  );
endinterface

`default_nettype wire

// File: rtl/apb_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module      : apb_bus_arbiter
// Description : Two-requester round-robin APB arbiter with one-hot peripheral
//               select decode and read-data/ready return mux.
//               Optional feature macro: APB_TIMEOUT_EN (forced completion with
//               timeoutErr after TIMEOUT_CYCLES ACCESS cycles).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_bus_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_SLAVES     = 4,   // must be <= 2**SEL_WIDTH
  parameter int SEL_WIDTH      = 2,
  parameter int SEL_LSB        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  apb_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic                    grant;        // 0 = m0, 1 = m1 owns current transfer
  logic                    last_grant;   // owner of last completed transfer
  logic                    grant_pick;
  logic                    any_req;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [SEL_WIDTH-1:0]    idx;
  logic [NUM_SLAVES-1:0]   sel_onehot;
  logic                    slave_ready;
  logic [DATA_WIDTH-1:0]   slave_rdata;
  logic [DATA_WIDTH-1:0]   rdata_out;
  logic [NUM_SLAVES-1:0]   psel;
  logic                    penable;
  logic                    done;
  logic                    complete;
  logic                    timeout_hit;

  // Contest goes to the requester that did not finish last; a lone requester always wins.
  assign any_req    = bus.m0Enable | bus.m1Enable;
  assign grant_pick = (bus.m0Enable && bus.m1Enable) ? ~last_grant : bus.m1Enable;
  assign idx        = addr_q[SEL_LSB +: SEL_WIDTH];

  // Slave decode: unmapped indexes fall through to forced ready with all-ones data.
  always_comb begin
    sel_onehot  = '0;
    slave_ready = 1'b1;
    slave_rdata = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SEL_WIDTH'(i)) begin
        sel_onehot[i] = 1'b1;
        slave_ready   = bus.pReady[i];
        slave_rdata   = bus.pRData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // Counts ACCESS cycles that passed without the selected slave being ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !slave_ready) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th ACCESS cycle; a real ready in that cycle wins.
  assign timeout_hit = (state == ACCESS) && !slave_ready &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register plus transfer latch and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        grant   <= grant_pick;
        addr_q  <= grant_pick ? bus.m1Addr  : bus.m0Addr;
        write_q <= grant_pick ? bus.m1Write : bus.m0Write;
        wdata_q <= grant_pick ? bus.m1WData : bus.m0WData;
      end
      if (done) begin
        last_grant <= grant;
      end
    end
  end

  // Next-state and APB phase outputs.
  always_comb begin
    state_next = state;
    psel       = '0;
    penable    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = SETUP;
      end
      SETUP: begin
        psel       = sel_onehot;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = sel_onehot;
        penable = 1'b1;
        if (slave_ready || timeout_hit) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A reset cycle aborts the transfer, so completion is suppressed while reset is high.
  assign complete  = done && !reset;
  assign rdata_out = slave_ready ? slave_rdata : '1;

  assign bus.m0Ready    = complete && !grant;
  assign bus.m1Ready    = complete && grant;
  assign bus.m0RData    = (complete && !grant) ? rdata_out : '0;
  assign bus.m1RData    = (complete && grant)  ? rdata_out : '0;
  assign bus.pSel       = psel;
  assign bus.pEnable    = penable;
  assign bus.pWrite     = write_q;
  assign bus.pAddr      = addr_q;
  assign bus.pWData     = wdata_q;
  assign bus.timeoutErr = timeout_hit && !reset;

endmodule

`default_nettype wire

// File: tb/tb_apb_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_apb_bus_arbiter
// Description : Scoreboard bench for apb_bus_arbiter. A 4-slave instance is
//               exercised with wait-state slaves; a 3-slave instance covers
//               the unmapped-index path. Honours APB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Cycle index used for expected ready timing.
  always @(posedge clk) cyc <= cyc + 1;

  apb_bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_SLAVES(4)) bus4 ();
  apb_bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_SLAVES(3)) bus3 ();

  apb_bus_arbiter #(.NUM_SLAVES(4)) dut  (.clk(clk), .reset(reset), .bus(bus4));
  apb_bus_arbiter #(.NUM_SLAVES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Peripheral model for the 4-slave bus: slave i is ready after waits[i] wait states.
  int          waits [4];
  logic [15:0] sdata [4];
  int          scnt;
  logic [3:0]  pr4;
  logic [63:0] prd4;

  always @(posedge clk) begin
    if (reset || !bus4.pEnable) scnt <= 0;
    else                        scnt <= scnt + 1;
  end

  always_comb begin
    pr4  = '0;
    prd4 = '0;
    for (int i = 0; i < 4; i++) begin
      pr4[i]           = bus4.pSel[i] && bus4.pEnable && (scnt == waits[i]);
      prd4[i*16 +: 16] = sdata[i];
    end
  end

  assign bus4.pReady = pr4;
  assign bus4.pRData = prd4;
  assign bus3.pReady = 3'b111;
  assign bus3.pRData = {16'h3333, 16'h2222, 16'h1111};

  typedef struct {
    int          m;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t e4;
  exp_t e3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push4(input int m, input logic [15:0] d, input int c);
    q4.push_back('{m: m, data: d, cyc: c});
  endtask

  // Monitor: every requester ready pulse is matched against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (bus4.m0Ready === 1'b1 || bus4.m1Ready === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready4 actual m0=%0b m1=%0b expected none (cycle %0d)",
                 bus4.m0Ready, bus4.m1Ready, cyc);
      end else begin
        e4 = q4.pop_front();
        chk("ready_port",  {31'd0, bus4.m1Ready}, e4.m);
        chk("other_ready", {31'd0, (e4.m != 0) ? bus4.m0Ready : bus4.m1Ready}, 0);
        chk("rdata", {16'd0, (e4.m != 0) ? bus4.m1RData : bus4.m0RData}, {16'd0, e4.data});
        chk("ready_cycle", cyc, e4.cyc);
      end
    end else if (!reset) begin
      chk("rdata_idle_zero", {bus4.m0RData, bus4.m1RData}, 32'd0);
    end
    if (bus3.m0Ready === 1'b1 || bus3.m1Ready === 1'b1) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready3 actual m0=%0b m1=%0b expected none (cycle %0d)",
                 bus3.m0Ready, bus3.m1Ready, cyc);
      end else begin
        e3 = q3.pop_front();
        chk("u_ready_port", {31'd0, bus3.m1Ready}, e3.m);
        chk("u_rdata", {16'd0, bus3.m0RData}, {16'd0, e3.data});
        chk("u_ready_cycle", cyc, e3.cyc);
      end
    end
  end

  // Runs until both requesters on bus4 have seen ready; each drops enable at its ready edge.
  task automatic run4(input int maxc);
    bit r0, r1;
    int k;
    k = 0;
    while ((bus4.m0Enable || bus4.m1Enable) && k < maxc) begin
      @(negedge clk);
      r0 = bus4.m0Ready;
      r1 = bus4.m1Ready;
      @(posedge clk); #1;
      if (r0) bus4.m0Enable = 1'b0;
      if (r1) bus4.m1Enable = 1'b0;
      k++;
    end
    if (k >= maxc) begin
      checks++;
      errors++;
      $display("FAIL run4_budget actual=%0d cycles expected completion", k);
      bus4.m0Enable = 1'b0;
      bus4.m1Enable = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    waits = '{0, 0, 0, 0};
    sdata = '{16'h1111, 16'hBEEF, 16'h3333, 16'h4444};
    bus4.m0Enable = 0; bus4.m0Write = 0; bus4.m0Addr = 0; bus4.m0WData = 0;
    bus4.m1Enable = 0; bus4.m1Write = 0; bus4.m1Addr = 0; bus4.m1WData = 0;
    bus3.m0Enable = 0; bus3.m0Write = 0; bus3.m0Addr = 0; bus3.m0WData = 0;
    bus3.m1Enable = 0; bus3.m1Write = 0; bus3.m1Addr = 0; bus3.m1WData = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", {28'd0, bus4.pSel}, 0);
    chk("rst_penable", {31'd0, bus4.pEnable}, 0);
    chk("rst_pwrite", {31'd0, bus4.pWrite}, 0);
    chk("rst_paddr", {24'd0, bus4.pAddr}, 0);
    chk("rst_pwdata", {16'd0, bus4.pWData}, 0);
    chk("rst_timeout", {31'd0, bus4.timeoutErr}, 0);
    chk("rst_ready", {30'd0, bus4.m0Ready, bus4.m1Ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Simultaneous after reset: m0 first, m1 in the IDLE cycle after m0 completes
    @(posedge clk); #1;
    n = cyc;
    bus4.m0Addr = 8'h02; bus4.m0Enable = 1;
    bus4.m1Addr = 8'h22; bus4.m1Enable = 1;
    push4(0, 16'h1111, n + 2);
    push4(1, 16'h3333, n + 5);
    run4(20);

    // m0 alone, zero-wait read of 0x12 from slave1
    n = cyc;
    bus4.m0Addr = 8'h12; bus4.m0Enable = 1;
    push4(0, 16'hBEEF, n + 2);
    @(negedge clk);
    chk("t1_psel_c0", {28'd0, bus4.pSel}, 0);
    @(negedge clk);
    chk("t1_psel_c1", {28'd0, bus4.pSel}, 32'h2);
    chk("t1_pen_c1", {31'd0, bus4.pEnable}, 0);
    chk("t1_paddr", {24'd0, bus4.pAddr}, 32'h12);
    @(negedge clk);
    chk("t1_psel_c2", {28'd0, bus4.pSel}, 32'h2);
    chk("t1_pen_c2", {31'd0, bus4.pEnable}, 1);
    @(posedge clk); #1;
    bus4.m0Enable = 0;
    @(negedge clk);
    chk("t1_psel_c3", {28'd0, bus4.pSel}, 0);
    chk("t1_pen_c3", {31'd0, bus4.pEnable}, 0);

    // Simultaneous again: m0 finished last, so m1 wins this time
    @(posedge clk); #1;
    n = cyc;
    bus4.m0Addr = 8'h02; bus4.m0Enable = 1;
    bus4.m1Addr = 8'h22; bus4.m1Enable = 1;
    push4(1, 16'h3333, n + 2);
    push4(0, 16'h1111, n + 5);
    run4(20);

    // m1 write 0x5A5A to slave3 with 3 wait states; requester lines change after latch
    waits[3] = 3;
    n = cyc;
    bus4.m1Addr = 8'h30; bus4.m1Write = 1; bus4.m1WData = 16'h5A5A; bus4.m1Enable = 1;
    push4(1, 16'h4444, n + 5);
    @(negedge clk);
    @(posedge clk); #1;
    bus4.m1WData = 16'h0000; bus4.m1Addr = 8'h00; bus4.m1Write = 0;
    @(negedge clk);
    chk("t3_psel_setup", {28'd0, bus4.pSel}, 32'h8);
    chk("t3_pen_setup", {31'd0, bus4.pEnable}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_pen", {31'd0, bus4.pEnable}, 1);
      chk("t3_psel", {28'd0, bus4.pSel}, 32'h8);
      chk("t3_pwrite", {31'd0, bus4.pWrite}, 1);
      chk("t3_pwdata", {16'd0, bus4.pWData}, 32'h5A5A);
    end
    @(posedge clk); #1;
    bus4.m1Enable = 0;
    waits[3] = 0;

    // Unmapped index on the 3-slave instance
    n = cyc;
    bus3.m0Addr = 8'h30; bus3.m0Enable = 1;
    q3.push_back('{m: 0, data: 16'hFFFF, cyc: n + 2});
    @(negedge clk);
    @(negedge clk);
    chk("u_psel_setup", {29'd0, bus3.pSel}, 0);
    @(negedge clk);
    chk("u_psel_access", {29'd0, bus3.pSel}, 0);
    chk("u_pen_access", {31'd0, bus3.pEnable}, 1);
    @(posedge clk); #1;
    bus3.m0Enable = 0;

    // Reset during ACCESS aborts without ready
    @(posedge clk); #1;
    waits[1] = 5;
    n = cyc;
    bus4.m0Addr = 8'h12; bus4.m0WData = 16'hA5A5; bus4.m0Write = 1; bus4.m0Enable = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    bus4.m0Enable = 0; bus4.m0Write = 0;
    @(negedge clk);
    chk("rs_no_ready", {31'd0, bus4.m0Ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rs_psel", {28'd0, bus4.pSel}, 0);
    chk("rs_pen", {31'd0, bus4.pEnable}, 0);
    chk("rs_paddr", {24'd0, bus4.pAddr}, 0);
    chk("rs_pwdata", {16'd0, bus4.pWData}, 0);
    chk("rs_pwrite", {31'd0, bus4.pWrite}, 0);
    waits[1] = 0;
    @(posedge clk); #1;
    n = cyc;
    bus4.m1Addr = 8'h12; bus4.m1Enable = 1;
    push4(1, 16'hBEEF, n + 2);
    run4(20);

`ifdef APB_TIMEOUT_EN
    // Slave never ready: forced completion in the 15th ACCESS cycle
    waits[0] = 100;
    n = cyc;
    bus4.m0Addr = 8'h02; bus4.m0Enable = 1;
    push4(0, 16'hFFFF, n + 16);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk("to_err", {31'd0, bus4.timeoutErr}, (k == 16) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    bus4.m0Enable = 0;
    @(posedge clk); #1;
    // Ready in the 15th ACCESS cycle completes normally
    waits[0] = 14;
    n = cyc;
    bus4.m0Enable = 1;
    push4(0, 16'h1111, n + 16);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk("to_noerr", {31'd0, bus4.timeoutErr}, 0);
    end
    @(posedge clk); #1;
    bus4.m0Enable = 0;
`else
    // Without the timeout feature a slow slave is simply waited for
    waits[0] = 20;
    n = cyc;
    bus4.m0Addr = 8'h02; bus4.m0Enable = 1;
    push4(0, 16'h1111, n + 22);
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      chk("nto_err", {31'd0, bus4.timeoutErr}, 0);
    end
    @(posedge clk); #1;
    bus4.m0Enable = 0;
`endif
    waits[0] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb4_drained", q4.size(), 0);
    chk("sb3_drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
